// File: rtl/fp16_adder.sv
// IEEE 754 binary16 adder, round-to-nearest-even, one-cycle registered latency.
// Handles subnormals, signed zeros, infinities and NaN (canonical quiet NaN out).
module fp16_adder #(
  parameter int unsigned FLOAT_LEN = 16,
  parameter int unsigned EXP_LEN   = 5,
  parameter int unsigned MANT_LEN  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [FLOAT_LEN-1:0] a,
  input  logic [FLOAT_LEN-1:0] b,
  output logic [FLOAT_LEN-1:0] result,
  output logic                 out_valid
);

  localparam int unsigned SIG_LEN   = MANT_LEN + 1;     // hidden bit + fraction
  localparam int unsigned EXT_LEN   = SIG_LEN + 3;      // plus guard, round, sticky
  localparam int unsigned ALIGN_LEN = 2 * EXT_LEN - 1;  // room for a 13-bit shift
  localparam int unsigned LZC_LEN   = 4;
  localparam int unsigned EW_LEN    = EXP_LEN + 1;      // exponent with overflow headroom
  localparam int unsigned MAG_LEN   = FLOAT_LEN - 1;
  localparam int unsigned MAX_SHIFT = 13;

  localparam logic [FLOAT_LEN-1:0] QNAN    = FLOAT_LEN'(16'h7E00);
  localparam logic [EXP_LEN-1:0]   EXP_ONES = '1;

  logic                 a_nan, b_nan, a_inf, b_inf;
  logic                 swap;
  logic [FLOAT_LEN-1:0] x, y;
  logic                 sign_x, sign_y, eff_sub;
  logic [EXP_LEN-1:0]   ex, ey, exp_diff;
  logic [SIG_LEN-1:0]   sig_x, sig_y;
  logic [LZC_LEN-1:0]   align_sh;
  logic [ALIGN_LEN-1:0] shifted;
  logic [EXT_LEN-1:0]   mx, my, m, m_n;
  logic [EXT_LEN:0]     raw_sum;
  logic [EW_LEN-1:0]    e, e_lim, e_n, norm_sh, exp_field;
  logic [LZC_LEN-1:0]   lzc;
  logic                 round_up;
  logic [FLOAT_LEN-1:0] packed_val;
  logic [FLOAT_LEN-1:0] sum_c;

  // Combinational add: unpack, order, align, add/sub, normalize, round, specials
  always_comb begin
    a_nan = (a[MAG_LEN-1 -: EXP_LEN] == EXP_ONES) && (a[MANT_LEN-1:0] != '0);
    b_nan = (b[MAG_LEN-1 -: EXP_LEN] == EXP_ONES) && (b[MANT_LEN-1:0] != '0);
    a_inf = (a[MAG_LEN-1 -: EXP_LEN] == EXP_ONES) && (a[MANT_LEN-1:0] == '0);
    b_inf = (b[MAG_LEN-1 -: EXP_LEN] == EXP_ONES) && (b[MANT_LEN-1:0] == '0);

    swap    = b[MAG_LEN-1:0] > a[MAG_LEN-1:0];
    x       = swap ? b : a;
    y       = swap ? a : b;
    sign_x  = x[FLOAT_LEN-1];
    sign_y  = y[FLOAT_LEN-1];
    eff_sub = sign_x ^ sign_y;

    // Subnormals use effective exponent 1 with a zero hidden bit
    ex    = (x[MAG_LEN-1 -: EXP_LEN] == '0) ? EXP_LEN'(1) : x[MAG_LEN-1 -: EXP_LEN];
    ey    = (y[MAG_LEN-1 -: EXP_LEN] == '0) ? EXP_LEN'(1) : y[MAG_LEN-1 -: EXP_LEN];
    sig_x = {(x[MAG_LEN-1 -: EXP_LEN] != '0), x[MANT_LEN-1:0]};
    sig_y = {(y[MAG_LEN-1 -: EXP_LEN] != '0), y[MANT_LEN-1:0]};

    exp_diff = ex - ey;
    align_sh = (exp_diff >= EXP_LEN'(MAX_SHIFT)) ? LZC_LEN'(MAX_SHIFT) : exp_diff[LZC_LEN-1:0];
    shifted  = {sig_y, (ALIGN_LEN - SIG_LEN)'(0)} >> align_sh;
    mx       = {sig_x, 3'b000};
    my       = {shifted[ALIGN_LEN-1 -: EXT_LEN-1], |shifted[EXT_LEN-1:0]};

    raw_sum = eff_sub ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});

    // Carry-out: shift right one, folding the lost bit into sticky
    if (raw_sum[EXT_LEN]) begin
      m = {raw_sum[EXT_LEN:2], raw_sum[1] | raw_sum[0]};
      e = EW_LEN'(ex) + EW_LEN'(1);
    end else begin
      m = raw_sum[EXT_LEN-1:0];
      e = EW_LEN'(ex);
    end

    lzc = LZC_LEN'(EXT_LEN);
    for (int unsigned i = 0; i < EXT_LEN; i++) begin
      if (m[i]) lzc = LZC_LEN'(EXT_LEN - 1 - i);
    end

    // Left shift stops at exponent 1; anything still unnormalized is subnormal
    e_lim     = e - EW_LEN'(1);
    norm_sh   = (EW_LEN'(lzc) > e_lim) ? e_lim : EW_LEN'(lzc);
    m_n       = m << norm_sh;
    e_n       = e - norm_sh;
    exp_field = m_n[EXT_LEN-1] ? e_n : '0;

    round_up   = m_n[2] & (m_n[1] | m_n[0] | m_n[3]);
    packed_val = {exp_field, m_n[EXT_LEN-2 -: MANT_LEN]} + FLOAT_LEN'(round_up);

    if (a_nan || b_nan) begin
      sum_c = QNAN;
    end else if (a_inf && b_inf && (a[FLOAT_LEN-1] != b[FLOAT_LEN-1])) begin
      sum_c = QNAN;
    end else if (a_inf) begin
      sum_c = a;
    end else if (b_inf) begin
      sum_c = b;
    end else if (eff_sub && (raw_sum == '0)) begin
      sum_c = '0;
    end else if (packed_val[FLOAT_LEN-1 -: EW_LEN] >= EW_LEN'(EXP_ONES)) begin
      sum_c = {sign_x, EXP_ONES, MANT_LEN'(0)};
    end else begin
      sum_c = {sign_x, packed_val[MAG_LEN-1:0]};
    end
  end

  // Output register; result holds when no new pair arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) result <= sum_c;
    end
  end

endmodule

// File: tb/tb_fp16_adder.sv
// Directed-vector and reference-model bench for fp16_adder.
module tb_fp16_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        out_valid;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  fp16_adder dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .result   (result),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  function automatic real pow2(input int e);
    real p = 1.0;
    if (e >= 0) repeat (e) p = p * 2.0;
    else repeat (-e) p = p / 2.0;
    return p;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real v;
    if (h[14:10] == 5'd0) v = real'(h[9:0]) * pow2(-24);
    else v = real'({1'b1, h[9:0]}) * pow2(int'(h[14:10]) - 25);
    return h[15] ? -v : v;
  endfunction

  // Round an exactly representable real to binary16, nearest-even
  function automatic logic [15:0] r2h(input real v);
    logic sgn;
    real  av, q, fl, fr;
    int   e, n, bits;
    sgn = (v < 0.0);
    av  = sgn ? -v : v;
    if (av == 0.0) return 16'h0000;
    if (av >= 65520.0) return sgn ? 16'hFC00 : 16'h7C00;
    e = 15;
    while (e > -14 && av < pow2(e)) e--;
    q  = av / pow2(e - 10);
    fl = $floor(q);
    fr = q - fl;
    n  = $rtoi(fl);
    if (fr > 0.5 || (fr == 0.5 && (n % 2) == 1)) n++;
    bits = (e + 14) * 1024 + n;
    if (bits >= 32'h7C00) return sgn ? 16'hFC00 : 16'h7C00;
    return {sgn, 15'(bits)};
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] y);
    real s;
    logic xn, yn, xi, yi;
    xn = (x[14:10] == 5'h1F) && (x[9:0] != 0);
    yn = (y[14:10] == 5'h1F) && (y[9:0] != 0);
    xi = (x[14:10] == 5'h1F) && (x[9:0] == 0);
    yi = (y[14:10] == 5'h1F) && (y[9:0] == 0);
    if (xn || yn) return 16'h7E00;
    if (xi && yi && x[15] != y[15]) return 16'h7E00;
    if (xi) return x;
    if (yi) return y;
    s = h2r(x) + h2r(y);
    if (s == 0.0) return (x == 16'h8000 && y == 16'h8000) ? 16'h8000 : 16'h0000;
    return r2h(s);
  endfunction

  task automatic issue(input logic [15:0] x, input logic [15:0] y);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] ra, rb, want, last;
    real rv;

    vecs.push_back('{16'h3E00, 16'hB800, 16'h3C00});
    vecs.push_back('{16'h4500, 16'hC500, 16'h0000});
    vecs.push_back('{16'h8000, 16'h8000, 16'h8000});
    vecs.push_back('{16'h0000, 16'h8000, 16'h0000});
    vecs.push_back('{16'h3C00, 16'h1000, 16'h3C00});
    vecs.push_back('{16'h3C01, 16'h1000, 16'h3C02});
    vecs.push_back('{16'h3C00, 16'h1001, 16'h3C01});
    vecs.push_back('{16'h3C00, 16'h8C00, 16'h3C00});
    vecs.push_back('{16'h0001, 16'h0001, 16'h0002});
    vecs.push_back('{16'h03FF, 16'h0001, 16'h0400});
    vecs.push_back('{16'h0400, 16'h8001, 16'h03FF});
    vecs.push_back('{16'h8001, 16'h8001, 16'h8002});
    vecs.push_back('{16'h0400, 16'h8400, 16'h0000});
    vecs.push_back('{16'h3555, 16'h3555, 16'h3955});
    vecs.push_back('{16'h4000, 16'hBC00, 16'h3C00});
    vecs.push_back('{16'h3C00, 16'h0001, 16'h3C00});
    vecs.push_back('{16'h7BFF, 16'h3C00, 16'h7BFF});
    vecs.push_back('{16'h7BFF, 16'h7BFF, 16'h7C00});
    vecs.push_back('{16'hFBFF, 16'hFBFF, 16'hFC00});
    vecs.push_back('{16'h7C00, 16'hFC00, 16'h7E00});
    vecs.push_back('{16'h7E00, 16'h3C00, 16'h7E00});
    vecs.push_back('{16'h3C00, 16'h7C01, 16'h7E00});
    vecs.push_back('{16'hFC00, 16'h4000, 16'hFC00});
    vecs.push_back('{16'h7C00, 16'h7C00, 16'h7C00});

    // Reset with a pending pair: it must be dropped
    rst = 1'b1;
    in_valid = 1'b1;
    a = 16'h3C00;
    b = 16'h3C00;
    repeat (2) begin
      @(posedge clk);
      #1;
      check16("reset_result", result, 16'h0000);
      check1("reset_out_valid", out_valid, 1'b0);
    end
    rst = 1'b0;
    issue(16'h3C00, 16'h3C00);
    check16("one_plus_one", result, 16'h4000);
    check1("one_plus_one_valid", out_valid, 1'b1);

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b);
      check16($sformatf("vec%0d_%h_%h", i, vecs[i].a, vecs[i].b), result, vecs[i].exp);
      check1($sformatf("vec%0d_valid", i), out_valid, 1'b1);
    end

    // Idle cycle: valid drops, result holds
    last = vecs[vecs.size()-1].exp;
    in_valid = 1'b0;
    a = 16'h3C00;
    b = 16'h3C00;
    @(posedge clk);
    #1;
    check1("idle_valid", out_valid, 1'b0);
    check16("idle_hold", result, last);

    // Back-to-back random pairs of magnitude below 100
    for (int i = 0; i < 10000; i++) begin
      rv = real'($urandom_range(0, 999999)) / 10000.0;
      ra = r2h(rv) | {$urandom_range(0, 1) == 1, 15'h0};
      rv = real'($urandom_range(0, 999999)) / 10000.0;
      rb = r2h(rv) | {$urandom_range(0, 1) == 1, 15'h0};
      want = ref_add(ra, rb);
      issue(ra, rb);
      check16($sformatf("rand%0d_%h_%h", i, ra, rb), result, want);
      check1("rand_valid", out_valid, 1'b1);
    end

    // Raw finite bit patterns reach subnormals and large exponents
    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (ra[14:10] == 5'h1F) ra[14] = 1'b0;
      if (rb[14:10] == 5'h1F) rb[14] = 1'b0;
      want = ref_add(ra, rb);
      issue(ra, rb);
      check16($sformatf("raw%0d_%h_%h", i, ra, rb), result, want);
    end

    // Mid-stream reset discards the in-flight and the concurrent pair
    issue(16'h4000, 16'h4000);
    check16("pre_reset_result", result, 16'h4400);
    a = 16'h4200;
    b = 16'h3C00;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check1("midreset_valid", out_valid, 1'b0);
    check16("midreset_result", result, 16'h0000);
    rst = 1'b0;
    issue(16'h4200, 16'h3C00);
    check16("post_reset_result", result, 16'h4400);
    check1("post_reset_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check1("final_idle_valid", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
